width_16to12: RTL and testbench
===============================

Name: width_16to12

Overview:
Downstream-side companion stage. It re-slices a stream of 16-bit words back into 12-bit words, in LSB-first order. Packet boundaries are marked with a last flag. The final partial word of a packet is zero-padded and flagged last. Ready/valid handshakes on both sides make it safe under output backpressure.

Parameters:
- None. Widths are fixed at 16 in and 12 out; the internal nibble granularity is 4 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  16  input word; bits [3:0] are the earliest nibble
- din_vld  in  1  input word valid
- din_vld_last  in  1  qualifies din_vld; marks the final word of a packet
- din_rdy  out  1  block can accept din this cycle; decoded from registers only
- dout  out  12  output word; bits [3:0] are the earliest nibble
- dout_vld  out  1  output word valid
- dout_vld_last  out  1  dout is the final word of the packet
- dout_rdy  in  1  downstream accepts dout this cycle

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, dout_vld=0, dout_vld_last=0.
  - Accumulator=0, nibble count cnt=0, state=RUN.
  - din_rdy=1 from the first cycle after release.
- Transfers:
  - Input transfer = din_vld && din_rdy. Output transfer = dout_vld && dout_rdy.
  - din_vld while din_rdy=0 is ignored; upstream holds din stable until accepted.
- Accumulator:
  - 28-bit register plus cnt in nibbles, range 0..7.
  - An accepted word is written at bit offset 4*(cnt - 3*emit), where emit is this cycle's load of dout.
  - On emit the accumulator shifts right by 12.
  - cnt_next = cnt + 4*accept - 3*emit_full - cnt*emit_pad.
- din_rdy = (state==RUN) && (cnt<=3). This guarantees no overflow of 7 nibbles.
- Output register is free when !dout_vld || dout_rdy. With the register free, the following rules apply:
  - emit_full when cnt>=3: dout<=acc[11:0], dout_vld<=1.
  - emit_pad when state==FLUSH and cnt is 1 or 2: dout<=acc[11:0] with upper nibbles zero, dout_vld<=1.
  - If free and neither emit condition holds: dout_vld<=0. dout holds its last value.
- dout_vld_last is loaded with the same emit and is 1 iff state==FLUSH and cnt<=3 at emit time. Otherwise it is 0.
- While dout_vld && !dout_rdy, dout, dout_vld and dout_vld_last are held unchanged.
- State machine:
  - RUN to FLUSH on accept with din_vld_last=1.
  - FLUSH to RUN on the emit that leaves cnt_next=0.
  - din_rdy stays 0 throughout FLUSH, so the next packet waits until the previous one fully drains.
- Latency: a word accepted at edge E produces its first dout_vld after edge E+1, given the output register is free.
- Throughput: sustains 3 input words per 4 cycles. Input stalls only when cnt>3.
- Packet sizing: N input words produce ceil(4N/3) outputs. Padding occurs only when N mod 3 != 0.
- Simultaneous events:
  - Accept and emit in the same cycle are both applied, in the order shift then insert.
  - Accepting the last word in the same cycle as an emit with cnt=3 does not flag that emit as last, because state is still RUN.
- Reset mid-packet: all residue is discarded, no last flag is produced, and the next packet starts clean.

Test Plan:
1. din 0x3210, 0x7654, 0xBA98 (last on third), dout_rdy=1 -> dout 0x210, 0x543, 0x876, 0xBA9; dout_vld_last only with 0xBA9; no padding.
2. Single word 0xABCD with last -> dout 0xBCD (last=0), then 0x00A (last=1); din_rdy=0 until 0x00A is emitted, then 1.
3. din 0x1111, 0x2222 (last on second) -> 0x111, 0x221, 0x022 with last on 0x022.
4. Backpressure: stream test 1 with dout_rdy=0 for 5 cycles after the first dout_vld -> dout held at 0x210; din_rdy drops once cnt>3; after release the sequence matches test 1 exactly, with no loss or duplication.
5. Back-to-back packets of 1 word then 3 words, din_vld held high -> second packet is accepted only after the first packet's last output; outputs 0xBCD, 0x00A(last), then the test 1 sequence.
6. Assert rst_n=0 after accepting 0x3210 with dout_rdy=0 -> dout, dout_vld and dout_vld_last are 0 immediately and din_rdy=1 after release; a following test 3 packet yields exactly its three expected outputs.

Source files
------------

// File: rtl/width_16to12.sv
// -----------------------------------------------------------------------------
// width_16to12
//   Re-slices a packetised stream of 16-bit words into 12-bit words,
//   earliest nibble in the LSBs on both sides. The tail of each packet is
//   zero-padded into a final 12-bit word, and that word is flagged last.
//   Ready/valid on both sides; the output register holds under backpressure.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   din[15:0]      input word, bits [3:0] earliest
//   din_vld        input word valid
//   din_vld_last   with din_vld: final word of the packet
//   din_rdy        block accepts din this cycle (decoded from registers only)
//   dout[11:0]     output word, bits [3:0] earliest
//   dout_vld       output word valid
//   dout_vld_last  dout is the final word of the packet
//   dout_rdy       downstream accepts dout this cycle
// -----------------------------------------------------------------------------
module width_16to12 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        din_vld_last,
    output logic        din_rdy,
    output logic [11:0] dout,
    output logic        dout_vld,
    output logic        dout_vld_last,
    input  logic        dout_rdy
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    // Accumulator holds up to 7 valid nibbles, oldest in the LSBs; bits above
    // 4*cnt are always zero.
    logic [27:0] acc;
    logic [27:0] acc_next;
    logic [27:0] acc_shifted;
    logic [2:0]  cnt;
    logic [2:0]  cnt_next;
    logic [2:0]  ins_base;

    logic        accept;
    logic        out_free;
    logic        emit_full;
    logic        emit_pad;
    logic        emit;
    logic        emit_last;
    logic [11:0] pad_word;

    // Accepting only when at most 3 nibbles remain keeps 3 + 4 <= 7.
    assign din_rdy   = (state == RUN) && (cnt <= 3'd3);
    assign accept    = din_vld && din_rdy;

    assign out_free  = !dout_vld || dout_rdy;
    assign emit_full = out_free && (cnt >= 3'd3);
    assign emit_pad  = out_free && (state == FLUSH) && ((cnt == 3'd1) || (cnt == 3'd2));
    assign emit      = emit_full || emit_pad;

    // In FLUSH no further input arrives, so an emit with cnt <= 3 drains
    // everything that is left.
    assign emit_last = (state == FLUSH) && (cnt <= 3'd3);

    // Tail word: only the nibbles still valid are passed, the rest are zero.
    always_comb begin
        pad_word = '0;
        if (cnt == 3'd1) begin
            pad_word = {8'h00, acc[3:0]};
        end else begin
            pad_word = {4'h0, acc[7:0]};
        end
    end

    // Shift out the emitted word first, then insert the accepted word just
    // above whatever remains.
    always_comb begin
        acc_shifted = acc;
        ins_base    = cnt;
        cnt_next    = cnt;
        if (emit_full) begin
            acc_shifted = acc >> 12;
            ins_base    = cnt - 3'd3;
            cnt_next    = cnt - 3'd3;
        end else if (emit_pad) begin
            acc_shifted = '0;
            cnt_next    = '0;
        end
        acc_next = acc_shifted;
        if (accept) begin
            acc_next = acc_shifted | ({12'h000, din} << {ins_base, 2'b00});
            cnt_next = cnt_next + 3'd4;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (accept && din_vld_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // cnt == 0 cannot normally occur in FLUSH; leaving anyway
                // keeps the block from locking up with din_rdy low.
                if ((emit && (cnt_next == 3'd0)) || (cnt == 3'd0)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout          <= '0;
            dout_vld      <= 1'b0;
            dout_vld_last <= 1'b0;
        end else if (out_free) begin
            if (emit_full) begin
                dout          <= acc[11:0];
                dout_vld      <= 1'b1;
                dout_vld_last <= emit_last;
            end else if (emit_pad) begin
                dout          <= pad_word;
                dout_vld      <= 1'b1;
                dout_vld_last <= emit_last;
            end else begin
                dout_vld      <= 1'b0;
                dout_vld_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_width_16to12.sv
module tb_width_16to12;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        din_vld;
    logic        din_vld_last;
    logic        din_rdy;
    logic [11:0] dout;
    logic        dout_vld;
    logic        dout_vld_last;
    logic        dout_rdy;

    int tests;
    int fails;

    // Captured output transfers, the din_rdy seen alongside each, and for each
    // accepted input the number of last-flagged outputs transferred so far.
    logic [11:0] out_d[$];
    bit          out_l[$];
    bit          out_rdy[$];
    int          acc_lasts[$];
    int          lasts_seen;

    width_16to12 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din           (din),
        .din_vld       (din_vld),
        .din_vld_last  (din_vld_last),
        .din_rdy       (din_rdy),
        .dout          (dout),
        .dout_vld      (dout_vld),
        .dout_vld_last (dout_vld_last),
        .dout_rdy      (dout_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1; everything is observed at negedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_vld && dout_rdy) begin
                out_d.push_back(dout);
                out_l.push_back(dout_vld_last);
                out_rdy.push_back(din_rdy);
                if (dout_vld_last) lasts_seen++;
            end
            if (din_vld && din_rdy) acc_lasts.push_back(lasts_seen);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_capture();
        out_d.delete();
        out_l.delete();
        out_rdy.delete();
        acc_lasts.delete();
        lasts_seen = 0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit lst);
        int cyc;
        cyc          = 0;
        din          = w;
        din_vld      = 1'b1;
        din_vld_last = lst;
        @(negedge clk);
        while (!din_rdy && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (!din_rdy) begin
            fails++;
            $display("FAIL send_timeout: word %h got din_rdy=0 after %0d cycles, required 1", w, cyc);
        end
        @(posedge clk);
        #1;
        din_vld      = 1'b0;
        din_vld_last = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int cyc;
        cyc = 0;
        while (out_d.size() < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (dout !== 12'h000) begin
            fails++;
            $display("FAIL reset_dout: got %h required 000", dout);
        end
        tests++;
        if (dout_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_dout_vld: got %b required 0", dout_vld);
        end
        tests++;
        if (dout_vld_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_dout_vld_last: got %b required 0", dout_vld_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (din_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_din_rdy: got %b required 1", din_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_three_word();
        logic [11:0] exp_d [4] = '{12'h210, 12'h543, 12'h876, 12'hBA9};
        bit          exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [11:0] got_d;
        bit          got_l;
        clear_capture();
        dout_rdy = 1'b1;
        send_word(16'h3210, 1'b0);
        send_word(16'h7654, 1'b0);
        send_word(16'hBA98, 1'b1);
        wait_outs(4);
        tests++;
        if (out_d.size() !== 4) begin
            fails++;
            $display("FAIL t1_count: got %0d outputs required 4", out_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            got_d = (i < out_d.size()) ? out_d[i] : 12'hFFF;
            got_l = (i < out_l.size()) ? out_l[i] : 1'b0;
            tests++;
            if (got_d !== exp_d[i]) begin
                fails++;
                $display("FAIL t1_dout[%0d]: got %h required %h", i, got_d, exp_d[i]);
            end
            tests++;
            if (got_l !== exp_l[i]) begin
                fails++;
                $display("FAIL t1_last[%0d]: got %b required %b", i, got_l, exp_l[i]);
            end
        end
    endtask

    task automatic test_single_pad();
        logic [11:0] exp_d [2] = '{12'hBCD, 12'h00A};
        bit          exp_l [2] = '{1'b0, 1'b1};
        bit          exp_r [2] = '{1'b0, 1'b1};
        logic [11:0] got_d;
        bit          got_l;
        bit          got_r;
        clear_capture();
        dout_rdy = 1'b1;
        send_word(16'hABCD, 1'b1);
        @(negedge clk);
        tests++;
        if (din_rdy !== 1'b0) begin
            fails++;
            $display("FAIL t2_rdy_after_last: got %b required 0", din_rdy);
        end
        wait_outs(2);
        tests++;
        if (out_d.size() !== 2) begin
            fails++;
            $display("FAIL t2_count: got %0d outputs required 2", out_d.size());
        end
        for (int i = 0; i < 2; i++) begin
            got_d = (i < out_d.size())   ? out_d[i]   : 12'hFFF;
            got_l = (i < out_l.size())   ? out_l[i]   : 1'b0;
            got_r = (i < out_rdy.size()) ? out_rdy[i] : 1'b0;
            tests++;
            if (got_d !== exp_d[i]) begin
                fails++;
                $display("FAIL t2_dout[%0d]: got %h required %h", i, got_d, exp_d[i]);
            end
            tests++;
            if (got_l !== exp_l[i]) begin
                fails++;
                $display("FAIL t2_last[%0d]: got %b required %b", i, got_l, exp_l[i]);
            end
            tests++;
            if (got_r !== exp_r[i]) begin
                fails++;
                $display("FAIL t2_din_rdy_at_out[%0d]: got %b required %b", i, got_r, exp_r[i]);
            end
        end
    endtask

    task automatic test_two_word();
        logic [11:0] exp_d [3] = '{12'h111, 12'h221, 12'h022};
        bit          exp_l [3] = '{1'b0, 1'b0, 1'b1};
        logic [11:0] got_d;
        bit          got_l;
        clear_capture();
        dout_rdy = 1'b1;
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b1);
        wait_outs(3);
        tests++;
        if (out_d.size() !== 3) begin
            fails++;
            $display("FAIL t3_count: got %0d outputs required 3", out_d.size());
        end
        for (int i = 0; i < 3; i++) begin
            got_d = (i < out_d.size()) ? out_d[i] : 12'hFFF;
            got_l = (i < out_l.size()) ? out_l[i] : 1'b0;
            tests++;
            if (got_d !== exp_d[i]) begin
                fails++;
                $display("FAIL t3_dout[%0d]: got %h required %h", i, got_d, exp_d[i]);
            end
            tests++;
            if (got_l !== exp_l[i]) begin
                fails++;
                $display("FAIL t3_last[%0d]: got %b required %b", i, got_l, exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_d [4] = '{12'h210, 12'h543, 12'h876, 12'hBA9};
        bit          exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [11:0] got_d;
        bit          got_l;
        clear_capture();
        dout_rdy = 1'b0;
        fork
            begin
                send_word(16'h3210, 1'b0);
                send_word(16'h7654, 1'b0);
                send_word(16'hBA98, 1'b1);
            end
            begin
                int cyc;
                cyc = 0;
                @(negedge clk);
                while (!dout_vld && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                for (int k = 0; k < 5; k++) begin
                    tests++;
                    if ({dout_vld, dout} !== {1'b1, 12'h210}) begin
                        fails++;
                        $display("FAIL t4_hold[%0d]: got vld=%b dout=%h required vld=1 dout=210",
                                 k, dout_vld, dout);
                    end
                    @(negedge clk);
                end
                tests++;
                if (din_rdy !== 1'b0) begin
                    fails++;
                    $display("FAIL t4_din_rdy_stall: got %b required 0", din_rdy);
                end
                @(posedge clk);
                #1;
                dout_rdy = 1'b1;
            end
        join
        wait_outs(4);
        tests++;
        if (out_d.size() !== 4) begin
            fails++;
            $display("FAIL t4_count: got %0d outputs required 4", out_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            got_d = (i < out_d.size()) ? out_d[i] : 12'hFFF;
            got_l = (i < out_l.size()) ? out_l[i] : 1'b0;
            tests++;
            if (got_d !== exp_d[i]) begin
                fails++;
                $display("FAIL t4_dout[%0d]: got %h required %h", i, got_d, exp_d[i]);
            end
            tests++;
            if (got_l !== exp_l[i]) begin
                fails++;
                $display("FAIL t4_last[%0d]: got %b required %b", i, got_l, exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_d [6] = '{12'hBCD, 12'h00A, 12'h210, 12'h543, 12'h876, 12'hBA9};
        bit          exp_l [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [11:0] got_d;
        bit          got_l;
        int          got_a;
        clear_capture();
        dout_rdy = 1'b1;
        send_word(16'hABCD, 1'b1);
        send_word(16'h3210, 1'b0);
        send_word(16'h7654, 1'b0);
        send_word(16'hBA98, 1'b1);
        wait_outs(6);
        tests++;
        if (out_d.size() !== 6) begin
            fails++;
            $display("FAIL t5_count: got %0d outputs required 6", out_d.size());
        end
        for (int i = 0; i < 6; i++) begin
            got_d = (i < out_d.size()) ? out_d[i] : 12'hFFF;
            got_l = (i < out_l.size()) ? out_l[i] : 1'b0;
            tests++;
            if (got_d !== exp_d[i]) begin
                fails++;
                $display("FAIL t5_dout[%0d]: got %h required %h", i, got_d, exp_d[i]);
            end
            tests++;
            if (got_l !== exp_l[i]) begin
                fails++;
                $display("FAIL t5_last[%0d]: got %b required %b", i, got_l, exp_l[i]);
            end
        end
        // Second packet's first word must wait for the first packet's last output.
        got_a = (acc_lasts.size() > 1) ? acc_lasts[1] : -1;
        tests++;
        if (got_a !== 1) begin
            fails++;
            $display("FAIL t5_second_pkt_gate: got %0d lasts before accept required 1", got_a);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [11:0] exp_d [3] = '{12'h111, 12'h221, 12'h022};
        bit          exp_l [3] = '{1'b0, 1'b0, 1'b1};
        logic [11:0] got_d;
        bit          got_l;
        clear_capture();
        dout_rdy = 1'b0;
        send_word(16'h3210, 1'b0);
        @(posedge clk);
        #1;
        tests++;
        if ({dout_vld, dout} !== {1'b1, 12'h210}) begin
            fails++;
            $display("FAIL t6_pre_reset: got vld=%b dout=%h required vld=1 dout=210", dout_vld, dout);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({dout_vld, dout_vld_last, dout} !== {1'b0, 1'b0, 12'h000}) begin
            fails++;
            $display("FAIL t6_async_reset: got vld=%b last=%b dout=%h required 0 0 000",
                     dout_vld, dout_vld_last, dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (din_rdy !== 1'b1) begin
            fails++;
            $display("FAIL t6_din_rdy_after_release: got %b required 1", din_rdy);
        end
        @(posedge clk);
        #1;
        clear_capture();
        dout_rdy = 1'b1;
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b1);
        wait_outs(3);
        tests++;
        if (out_d.size() !== 3) begin
            fails++;
            $display("FAIL t6_count: got %0d outputs required 3", out_d.size());
        end
        for (int i = 0; i < 3; i++) begin
            got_d = (i < out_d.size()) ? out_d[i] : 12'hFFF;
            got_l = (i < out_l.size()) ? out_l[i] : 1'b0;
            tests++;
            if (got_d !== exp_d[i]) begin
                fails++;
                $display("FAIL t6_dout[%0d]: got %h required %h", i, got_d, exp_d[i]);
            end
            tests++;
            if (got_l !== exp_l[i]) begin
                fails++;
                $display("FAIL t6_last[%0d]: got %b required %b", i, got_l, exp_l[i]);
            end
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        lasts_seen   = 0;
        rst_n        = 1'b0;
        din          = '0;
        din_vld      = 1'b0;
        din_vld_last = 1'b0;
        dout_rdy     = 1'b1;

        test_reset();
        test_three_word();
        test_single_pad();
        test_two_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
